// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, HI/LO op-codes, multiply/divide FSM states.
// Also holds the two's-complement negation used for sign fix-up outside the iteration adder.
package mips_pkg;

   localparam int WIDTH = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      RUN  = 2'd2,
      FIX  = 2'd3
   } md_state_t;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Decode-side bundle of the multiply/divide unit: launch, MTHI/MTLO writes, status and HI/LO.
// The master modport is the ALU/decode stage; the slave modport is the unit itself.
interface mult_div_unit_if;
   import mips_pkg::*;

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs, rt, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, rs, rt, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/mult_div_unit_adder.sv
// 32-bit ripple-carry adder, purely combinational; the single add/subtract resource of the
// multiply/divide unit (subtract = inverted operand with carry-in set by the caller).
module adder_32
   import mips_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   always_comb begin
      logic carry;
      carry = cin;
      sum   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU into HI/LO, one bit per clock through a shared adder_32.
// Result lands 34 cycles after the start edge; start and MTHI/MTLO are ignored while busy.
module mult_div_unit
   import mips_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   mult_div_unit_if.slave bus
);

   md_state_t          state, state_nxt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   rs_q, rt_q;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   acc_hi, acc_lo;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [4:0]         cnt;
   logic               neg_prod, neg_rem;
   logic               done_q;

   logic               is_div, is_signed;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [WIDTH-1:0]   rem_sh;
   logic [WIDTH-1:0]   add_a, add_b, add_sum;
   logic               add_cin, add_cout;
   logic               q_bit;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign is_div    = op_q[1];
   assign is_signed = op_q[0];

   assign rs_mag = (is_signed && rs_q[WIDTH-1]) ? negate(rs_q) : rs_q;
   assign rt_mag = (is_signed && rt_q[WIDTH-1]) ? negate(rt_q) : rt_q;

   // Divide uses the adder as rem - divisor; the shifted-out bit acts as a 33rd remainder bit.
   assign rem_sh  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
   assign add_a   = is_div ? rem_sh : acc_hi;
   assign add_b   = is_div ? ~opnd : opnd;
   assign add_cin = is_div;
   assign q_bit   = acc_hi[WIDTH-1] | add_cout;

   adder_32 u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign prod     = {acc_hi, acc_lo};
   assign prod_neg = ~prod + (2*WIDTH)'(1);
   assign q_fix    = (is_signed && neg_prod) ? negate(acc_lo) : acc_lo;
   assign r_fix    = (is_signed && neg_rem)  ? negate(acc_hi) : acc_hi;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = PREP;
         PREP:    state_nxt = RUN;
         RUN:     if (cnt == 5'd31) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q     <= OP_MULTU;
         rs_q     <= '0;
         rt_q     <= '0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt      <= '0;
         neg_prod <= 1'b0;
         neg_rem  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.hi_we) hi_q <= bus.wdata;
               if (bus.lo_we) lo_q <= bus.wdata;
               if (bus.start) begin
                  op_q <= bus.op;
                  rs_q <= bus.rs;
                  rt_q <= bus.rt;
               end
            end
            PREP: begin
               acc_hi   <= '0;
               cnt      <= '0;
               neg_prod <= is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
               neg_rem  <= is_signed & rs_q[WIDTH-1];
               if (is_div) begin
                  acc_lo <= rs_mag;
                  opnd   <= rt_mag;
               end else begin
                  acc_lo <= rt_mag;
                  opnd   <= rs_mag;
               end
            end
            RUN: begin
               cnt <= cnt + 5'd1;
               if (is_div) begin
                  acc_hi <= q_bit ? add_sum : rem_sh;
                  acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
               end else if (acc_lo[0]) begin
                  acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
                  acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
               end else begin
                  acc_hi <= {1'b0, acc_hi[WIDTH-1:1]};
                  acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
               end
            end
            FIX: begin
               done_q <= 1'b1;
               if (!is_div) begin
                  {hi_q, lo_q} <= (is_signed && neg_prod) ? prod_neg : prod;
               end else if (opnd == '0) begin
                  hi_q <= rs_q;
                  lo_q <= '1;
               end else begin
                  hi_q <= r_fix;
                  lo_q <= q_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: hand-computed HI/LO results, latency,
// back-to-back issue, dropped start/MTHI while busy, MTHI/MTLO while idle, mid-operation reset.
module tb_mult_div_unit;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   lat;
   logic done_seen;

   always #5 clk = ~clk;

   mult_div_unit_if bus ();

   mult_div_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge of the done cycle (or on timeout).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.rs    = a;
      bus.rt    = b;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      bus.start = 1'b0;
      while (!bus.done && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic step();
      @(posedge clk);
      lat++;
      @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = OP_MULTU;
      bus.rs    = '0;
      bus.rt    = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_lat", lat, 32'd34);
      chk("multu_busy_in_done", 32'(bus.busy), 32'd0);
      chk("multu_hi", bus.hi, 32'hFFFFFFFE);
      chk("multu_lo", bus.lo, 32'h00000001);

      // issued in the done cycle of the previous operation
      run_op(OP_MULT, 32'hFFFFFFFD, 32'd7);
      chk("b2b_lat", lat, 32'd34);
      chk("mult_neg_hi", bus.hi, 32'hFFFFFFFF);
      chk("mult_neg_lo", bus.lo, 32'hFFFFFFEB);

      run_op(OP_MULT, 32'h80000000, 32'h80000000);
      chk("mult_min_hi", bus.hi, 32'h40000000);
      chk("mult_min_lo", bus.lo, 32'h00000000);

      run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
      chk("div_neg_lo", bus.lo, 32'hFFFFFFFD);
      chk("div_neg_hi", bus.hi, 32'hFFFFFFFF);

      run_op(OP_DIV, 32'd7, 32'hFFFFFFFE);
      chk("div_negdiv_lo", bus.lo, 32'hFFFFFFFD);
      chk("div_negdiv_hi", bus.hi, 32'h00000001);

      run_op(OP_DIVU, 32'd100, 32'd7);
      chk("divu_lo", bus.lo, 32'd14);
      chk("divu_hi", bus.hi, 32'd2);

      run_op(OP_DIVU, 32'd100, 32'd0);
      chk("divu0_lat", lat, 32'd34);
      chk("divu0_hi", bus.hi, 32'd100);
      chk("divu0_lo", bus.lo, 32'hFFFFFFFF);

      run_op(OP_DIV, 32'hFFFFFFF6, 32'd0);
      chk("div0_hi", bus.hi, 32'hFFFFFFF6);
      chk("div0_lo", bus.lo, 32'hFFFFFFFF);

      run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      chk("div_ovf_lo", bus.lo, 32'h80000000);
      chk("div_ovf_hi", bus.hi, 32'h00000000);

      // MTHI / MTLO while idle
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.wdata = 32'h00001234;
      @(negedge clk);
      bus.hi_we = 1'b0;
      chk("mthi_idle", bus.hi, 32'h00001234);
      bus.lo_we = 1'b1;
      bus.wdata = 32'h00005678;
      @(negedge clk);
      bus.lo_we = 1'b0;
      chk("mtlo_idle", bus.lo, 32'h00005678);

      // MTHI and a second start while busy are both dropped
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.rs    = 32'd3;
      bus.rt    = 32'd5;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000DEAD;
      step();
      bus.hi_we = 1'b0;
      chk("busy_during_op", 32'(bus.busy), 32'd1);
      chk("mthi_busy_dropped", bus.hi, 32'h00001234);
      while (lat < 6) step();
      bus.start = 1'b1;
      bus.op    = OP_DIVU;
      bus.rs    = 32'd1;
      bus.rt    = 32'd1;
      step();
      bus.start = 1'b0;
      chk("lo_stable_busy", bus.lo, 32'h00005678);
      while (!bus.done && lat < 100) step();
      chk("ignored_start_lat", lat, 32'd34);
      chk("ignored_start_hi", bus.hi, 32'd0);
      chk("ignored_start_lo", bus.lo, 32'd15);
      @(negedge clk);
      chk("no_queued_op", 32'(bus.busy), 32'd0);

      // reset during RUN iteration 10
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000BEEF;
      @(negedge clk);
      bus.hi_we = 1'b0;
      run_op_partial();
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_hi", bus.hi, 32'h0);
      chk("midrst_lo", bus.lo, 32'h0);
      rst_n = 1'b1;
      done_seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) done_seen = 1'b1;
      end
      chk("midrst_no_done", 32'(done_seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic run_op_partial();
      bus.start = 1'b1;
      bus.op    = OP_MULTU;
      bus.rs    = 32'hFFFFFFFF;
      bus.rt    = 32'hFFFFFFFF;
      @(posedge clk);
      lat = 0;
      @(negedge clk);
      bus.start = 1'b0;
      while (lat < 11) step();
   endtask

endmodule
